// File: rtl/raccoon_pkg.sv
// Shared Raccoon ring definitions: beat layout, type encodings and address-hit helper.
package raccoon_pkg;

    localparam int unsigned RACC_W = 80;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;
    localparam int unsigned TAG_W  = 12;
    localparam int unsigned CNT_W  = 8;

    localparam logic [1:0] RACC_TYPE_REQ = 2'b00;
    localparam logic [1:0] RACC_TYPE_RSP = 2'b10;

    // Field order fixes the bit positions: valid[79] write[78] type[77:76] tag[75:64] data[63:32] addr[31:0].
    typedef struct packed {
        logic                     valid;
        logic                     write;
        logic [1:0]               kind;
        logic [TAG_W-MASK_W-1:0]  attr;
        logic [MASK_W-1:0]        mask;
        logic [DATA_W-1:0]        data;
        logic [ADDR_W-1:0]        addr;
    } racc_beat_t;

    function automatic logic racc_is_hit(
        input racc_beat_t        beat,
        input logic [ADDR_W-1:0] addr_mask,
        input logic [ADDR_W-1:0] addr_base
    );
        return beat.valid && (beat.kind == RACC_TYPE_REQ)
            && ((beat.addr & addr_mask) == (addr_base & addr_mask));
    endfunction

endpackage

// File: rtl/raccoon_starve_cnt.sv
// Saturating count of cycles the waiting local requester lost to a Raccoon hit.
module raccoon_starve_cnt
    import raccoon_pkg::*;
#(
    parameter int unsigned LIMIT = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic lcl_req,
    input  logic lcl_gnt,
    input  logic racc_hit,
    output logic at_limit_c
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (!RST || !lcl_req || lcl_gnt) begin
            cnt <= '0;
        end else if (racc_hit && (cnt != LIMIT_C)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign at_limit_c = (cnt == LIMIT_C);

endmodule

// File: rtl/raccoon_ram_arb.sv
// Shares one RAM port between Raccoon ring requests and a local requester; ring latency is a fixed 3 cycles.
module raccoon_ram_arb
    import raccoon_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_MASK    = 32'hFFFF0000,
    parameter logic [ADDR_W-1:0] ADDR_BASE    = 32'h00010000,
    parameter int unsigned       STARVE_LIMIT = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [RACC_W-1:0] RaccIn,
    output logic [RACC_W-1:0] RaccOut,
    input  logic              LCL_REQ,
    input  logic              LCL_WE,
    input  logic [ADDR_W-1:0] LCL_ADDR,
    input  logic [MASK_W-1:0] LCL_MASK,
    input  logic [DATA_W-1:0] LCL_WR_DATA,
    output logic              LCL_GNT,
    output logic              LCL_RD_VALID,
    output logic [DATA_W-1:0] LCL_RD_DATA,
    output logic              CS,
    output logic              WE,
    output logic [ADDR_W-1:0] ADDR,
    output logic [MASK_W-1:0] MASK,
    output logic [DATA_W-1:0] WR_DATA,
    input  logic [DATA_W-1:0] RD_DATA
);

    racc_beat_t din;
    racc_beat_t din_d1;
    racc_beat_t racc_rsp;
    logic       win_d1;
    logic       rd_valid;
    logic       racc_hit;
    logic       racc_win;
    logic       lcl_gnt;
    logic       starve_sat;

    assign racc_hit = racc_is_hit(din, ADDR_MASK, ADDR_BASE);

    raccoon_starve_cnt #(
        .LIMIT      (STARVE_LIMIT)
    ) u_starve_cnt (
        .CLK        (CLK),
        .RST        (RST),
        .lcl_req    (LCL_REQ),
        .lcl_gnt    (lcl_gnt),
        .racc_hit   (racc_hit),
        .at_limit_c (starve_sat)
    );

    // Local wins when the ring has nothing for us or has starved it long enough; reset blocks both.
    assign lcl_gnt  = RST && LCL_REQ && (!racc_hit || starve_sat);
    assign racc_win = RST && racc_hit && !lcl_gnt;
    assign LCL_GNT  = lcl_gnt;

    always_comb begin
        CS      = racc_win || lcl_gnt;
        WE      = LCL_WE;
        ADDR    = LCL_ADDR;
        MASK    = LCL_MASK;
        WR_DATA = LCL_WR_DATA;
        if (racc_win) begin
            WE      = din.write;
            ADDR    = din.addr;
            MASK    = din.mask;
            WR_DATA = din.data;
        end
    end

    // Serviced beats turn into responses carrying the RAM word; writes answer the same way as reads.
    always_comb begin
        racc_rsp      = din_d1;
        racc_rsp.kind = RACC_TYPE_RSP;
        racc_rsp.data = RD_DATA;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            din      <= '0;
            din_d1   <= '0;
            win_d1   <= 1'b0;
            RaccOut  <= '0;
            rd_valid <= 1'b0;
        end else begin
            din      <= racc_beat_t'(RaccIn);
            din_d1   <= din;
            win_d1   <= racc_win;
            RaccOut  <= win_d1 ? racc_rsp : din_d1;
            rd_valid <= lcl_gnt && !LCL_WE;
        end
    end

    assign LCL_RD_VALID = rd_valid;
    assign LCL_RD_DATA  = RD_DATA;

endmodule

// File: tb/tb_raccoon_ram_arb.sv
// Directed plus randomized checks of raccoon_ram_arb against a cycle-level reference model.
module tb_raccoon_ram_arb;

    localparam int LIMIT = 8;

    logic        CLK;
    logic        RST;
    logic [79:0] RaccIn;
    logic [79:0] RaccOut;
    logic        LCL_REQ;
    logic        LCL_WE;
    logic [31:0] LCL_ADDR;
    logic [3:0]  LCL_MASK;
    logic [31:0] LCL_WR_DATA;
    logic        LCL_GNT;
    logic        LCL_RD_VALID;
    logic [31:0] LCL_RD_DATA;
    logic        CS;
    logic        WE;
    logic [31:0] ADDR;
    logic [3:0]  MASK;
    logic [31:0] WR_DATA;
    logic [31:0] RD_DATA;

    raccoon_ram_arb #(
        .ADDR_MASK    (32'hFFFF0000),
        .ADDR_BASE    (32'h00010000),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RaccIn       (RaccIn),
        .RaccOut      (RaccOut),
        .LCL_REQ      (LCL_REQ),
        .LCL_WE       (LCL_WE),
        .LCL_ADDR     (LCL_ADDR),
        .LCL_MASK     (LCL_MASK),
        .LCL_WR_DATA  (LCL_WR_DATA),
        .LCL_GNT      (LCL_GNT),
        .LCL_RD_VALID (LCL_RD_VALID),
        .LCL_RD_DATA  (LCL_RD_DATA),
        .CS           (CS),
        .WE           (WE),
        .ADDR         (ADDR),
        .MASK         (MASK),
        .WR_DATA      (WR_DATA),
        .RD_DATA      (RD_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RAM attached to the DUT: 16 words, read data one cycle after CS, byte-masked writes.
    logic [31:0] ram [16];
    always @(posedge CLK) begin
        if (CS) begin
            RD_DATA <= ram[ADDR[5:2]];
            if (WE) begin
                for (int b = 0; b < 4; b++) begin
                    if (MASK[b]) ram[ADDR[5:2]][8*b +: 8] <= WR_DATA[8*b +: 8];
                end
            end
        end
    end

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] ref_mem [16];
    logic [79:0] ref_din;
    logic [79:0] exp_q [$];
    logic        exp_rdv;
    logic [31:0] exp_rdd;
    int          ref_cnt;
    logic        last_gnt;

    // Local requester stimulus state
    logic        l_req;
    logic        l_we;
    logic [31:0] l_addr;
    logic [3:0]  l_mask;
    logic [31:0] l_wd;

    logic [79:0] idle;
    logic [79:0] b1;
    logic [79:0] b2;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] beat(input logic v, input logic w, input logic [1:0] k,
                                         input logic [11:0] tag, input logic [31:0] d,
                                         input logic [31:0] a);
        return {v, w, k, tag, d, a};
    endfunction

    function automatic logic [79:0] rand_beat();
        logic [1:0]  k;
        logic [15:0] upper;
        logic [31:0] a;
        int r;
        r = $urandom_range(0, 9);
        k = (r < 6) ? 2'b00 : (r < 8) ? 2'b10 : 2'($urandom_range(0, 3));
        upper = 16'($urandom);
        if (upper == 16'h0001) upper = 16'h0000;
        a = ($urandom_range(0, 3) != 0) ? {16'h0001, 16'($urandom)} : {upper, 16'($urandom)};
        return {($urandom_range(0, 3) != 0), 1'($urandom), k, 12'($urandom), 32'($urandom), a};
    endfunction

    task automatic model_reset();
        ref_din = '0;
        exp_q.delete();
        exp_q.push_back('0);
        exp_q.push_back('0);
        exp_rdv  = 1'b0;
        exp_rdd  = '0;
        ref_cnt  = 0;
        last_gnt = 1'b0;
    endtask

    task automatic drive(input logic rst, input logic [79:0] rin);
        RST         = rst;
        RaccIn      = rin;
        LCL_REQ     = l_req;
        LCL_WE      = l_we;
        LCL_ADDR    = l_addr;
        LCL_MASK    = l_mask;
        LCL_WR_DATA = l_wd;
    endtask

    task automatic check_regs();
        chk("racc_out", RaccOut, exp_q.pop_front());
        chk("rd_valid", 80'(LCL_RD_VALID), 80'(exp_rdv));
        if (exp_rdv) chk("rd_data", 80'(LCL_RD_DATA), 80'(exp_rdd));
    endtask

    // One cycle: present new inputs, check outputs, then advance the model by the spec's rules.
    task automatic step(input logic [79:0] rin);
        logic        hit, gnt, win, wr;
        logic [31:0] a, wd, rdata;
        logic [3:0]  msk;
        logic [79:0] out;
        @(negedge CLK);
        drive(1'b1, rin);
        #1;
        check_regs();
        hit = ref_din[79] && (ref_din[77:76] == 2'b00) && (ref_din[31:16] == 16'h0001);
        gnt = l_req && (!hit || ref_cnt >= LIMIT);
        win = hit && !gnt;
        chk("lcl_gnt", 80'(LCL_GNT), 80'(gnt));
        chk("cs", 80'(CS), 80'(gnt || win));
        wr    = win ? ref_din[78]    : l_we;
        a     = win ? ref_din[31:0]  : l_addr;
        msk   = win ? ref_din[67:64] : l_mask;
        wd    = win ? ref_din[63:32] : l_wd;
        rdata = '0;
        if (gnt || win) begin
            chk("ram_we", 80'(WE), 80'(wr));
            chk("ram_addr", 80'(ADDR), 80'(a));
            chk("ram_mask", 80'(MASK), 80'(msk));
            chk("ram_wdata", 80'(WR_DATA), 80'(wd));
            rdata = ref_mem[a[5:2]];
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (msk[b]) ref_mem[a[5:2]][8*b +: 8] = wd[8*b +: 8];
                end
            end
        end
        out = ref_din;
        if (win) out = {ref_din[79:78], 2'b10, ref_din[75:64], rdata, ref_din[31:0]};
        exp_q.push_back(out);
        exp_rdv = gnt && !l_we;
        exp_rdd = rdata;
        if (!l_req || gnt) ref_cnt = 0;
        else if (hit && ref_cnt < LIMIT) ref_cnt = ref_cnt + 1;
        last_gnt = gnt;
        ref_din  = rin;
    endtask

    task automatic do_reset(input logic [79:0] rin);
        @(negedge CLK);
        drive(1'b0, rin);
        #1;
        check_regs();
        chk("rst_cs", 80'(CS), 80'(0));
        chk("rst_gnt", 80'(LCL_GNT), 80'(0));
        model_reset();
    endtask

    initial begin
        idle   = '0;
        l_req  = 1'b0;
        l_we   = 1'b0;
        l_addr = '0;
        l_mask = '0;
        l_wd   = '0;
        for (int i = 0; i < 16; i++) begin
            logic [31:0] v;
            v = $urandom;
            ram[i]     <= v;
            ref_mem[i]  = v;
        end
        ram[4]     <= 32'hCAFEF00D;
        ref_mem[4]  = 32'hCAFEF00D;
        drive(1'b0, idle);
        repeat (2) @(posedge CLK);
        model_reset();

        // Raccoon read serviced
        step(beat(1'b1, 1'b0, 2'b00, 12'h5A0, 32'h0, 32'h00010010));
        step(idle);
        step(idle);
        step(idle);
        chk("rd_rsp_type", 80'(RaccOut[77:76]), 80'(2'b10));
        chk("rd_rsp_data", 80'(RaccOut[63:32]), 80'(32'hCAFEF00D));
        chk("rd_rsp_addr", 80'(RaccOut[31:0]), 80'(32'h00010010));

        // Raccoon write serviced
        step(beat(1'b1, 1'b1, 2'b00, 12'h003, 32'h11223344, 32'h00010004));
        step(idle);
        chk("wr_cs", 80'(CS), 80'(1));
        chk("wr_we", 80'(WE), 80'(1));
        chk("wr_mask", 80'(MASK), 80'(4'b0011));
        step(idle);
        step(idle);
        chk("wr_rsp_type", 80'(RaccOut[77:76]), 80'(2'b10));

        // Local read with an idle ring
        l_req = 1'b1; l_we = 1'b0; l_addr = 32'h00010020; l_mask = 4'hF; l_wd = '0;
        step(idle);
        chk("lcl_gnt_now", 80'(LCL_GNT), 80'(1));
        l_req = 1'b0;
        step(idle);
        chk("lcl_rdv_next", 80'(LCL_RD_VALID), 80'(1));

        // Starvation: local held against 10 consecutive hits
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'h0001003C; l_mask = 4'h1; l_wd = 32'hA5;
        for (int i = 0; i < 10; i++) begin
            step(beat(1'b1, 1'b0, 2'b00, 12'(i), 32'(i), {26'h0000400, 4'(i), 2'b00}));
            if (i > 0) chk("starve_gnt", 80'(LCL_GNT), 80'(i == 9));
        end
        step(idle);
        chk("starve_after", 80'(LCL_GNT), 80'(0));
        l_req = 1'b0;
        step(idle);
        chk("bounce_exit", RaccOut, beat(1'b1, 1'b0, 2'b00, 12'd8, 32'd8, {26'h0000400, 4'd8, 2'b00}));

        // Pass-through: out-of-window request and an in-window response
        b1 = beat(1'b1, 1'b0, 2'b00, 12'h777, 32'hDEADBEEF, 32'h00020000);
        b2 = beat(1'b1, 1'b1, 2'b10, 12'h0F1, 32'h01234567, 32'h00010008);
        step(b1);
        step(b2);
        chk("pass_cs1", 80'(CS), 80'(0));
        step(idle);
        chk("pass_cs2", 80'(CS), 80'(0));
        step(idle);
        chk("pass_out1", RaccOut, b1);
        step(idle);
        chk("pass_out2", RaccOut, b2);

        // Reset mid-traffic right after a granted local read
        step(idle);
        l_req = 1'b1; l_we = 1'b0; l_addr = 32'h00010030; l_mask = 4'hF;
        step(beat(1'b1, 1'b0, 2'b00, 12'h123, 32'h0, 32'h00010014));
        chk("pre_rst_gnt", 80'(LCL_GNT), 80'(1));
        do_reset(beat(1'b1, 1'b0, 2'b00, 12'h124, 32'h0, 32'h00010018));
        l_req = 1'b0;
        step(idle);
        chk("post_rst_out", RaccOut, 80'(0));
        chk("post_rst_rdv", 80'(LCL_RD_VALID), 80'(0));
        chk("post_rst_cs", 80'(CS), 80'(0));

        // Randomized traffic; local requests held until the model grants them
        for (int i = 0; i < 400; i++) begin
            if (!(l_req && !last_gnt)) begin
                l_req  = ($urandom_range(0, 1) == 1);
                l_we   = 1'($urandom);
                l_addr = {16'h0001, 16'($urandom)};
                l_mask = 4'($urandom);
                l_wd   = $urandom;
            end
            step(rand_beat());
        end
        l_req = 1'b0;
        repeat (3) step(idle);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/raccoon_ram_arb.md
RACCOON_RAM_ARB -- requirements
Module: raccoon_ram_arb

Interface
REQ-001 SHALL have parameter ADDR_MASK, default 32'hFFFF0000, meaning the address bits compared for a Raccoon hit.
REQ-002 SHALL have parameter ADDR_BASE, default 32'h00010000, meaning the matched base address.
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, meaning the number of denied local cycles before the local port wins unconditionally (legal range 1..255).
REQ-004 CLK  input  1  single clock; all logic on rising edge.
REQ-005 RST  input  1  reset, synchronous, active-low.
REQ-006 RaccIn  input  80  Raccoon bus in: [79] valid, [78] write, [77:76] type (00 request, 10 response), [75:64] tag/attributes ([67:64] byte mask), [63:32] data, [31:0] address.
REQ-007 RaccOut  output  80  Raccoon bus out, same field layout.
REQ-008 LCL_REQ  input  1  local requester access request, held until granted.
REQ-009 LCL_WE  input  1  local write (1) or read (0).
REQ-010 LCL_ADDR  input  32  local address; LCL_MASK  input  4  byte mask; LCL_WR_DATA  input  32  write data.
REQ-011 LCL_GNT  output  1  local access issued to RAM this cycle.
REQ-012 LCL_RD_VALID  output  1  LCL_RD_DATA valid; LCL_RD_DATA  output  32  local read data.
REQ-013 CS, WE  output  1 each; ADDR  output  32; MASK  output  4; WR_DATA  output  32: RAM port; RD_DATA  input  32, valid the cycle after a CS read.

Function
REQ-014 SHALL register RaccIn into stage din every cycle; racc_hit = din[79] & (din[77:76]==00) & ((din[31:0]&ADDR_MASK)==(ADDR_BASE&ADDR_MASK)).
REQ-015 SHALL grant local when LCL_REQ & (!racc_hit | starve_cnt==STARVE_LIMIT); otherwise a racc_hit wins.
REQ-016 SHALL drive CS = racc_win | LCL_GNT, with WE/ADDR/MASK/WR_DATA muxed from din ([78], [31:0], [67:64], [63:32]) or the LCL_* inputs, combinationally in the grant cycle.
REQ-017 SHALL keep starve_cnt 8 bits: increment, saturating at STARVE_LIMIT, when LCL_REQ & !LCL_GNT & racc_hit; clear on LCL_GNT or !LCL_REQ.
REQ-018 SHALL delay din to din_d1 and the Raccoon win to win_d1 by one cycle; RaccOut registers {din_d1[79:78], 2'b10, din_d1[75:64], RD_DATA, din_d1[31:0]} if win_d1, else din_d1 unchanged.
REQ-019 SHALL give RaccIn->RaccOut latency of exactly 3 cycles for every beat, serviced or not.
REQ-020 SHALL forward a racc_hit that loses arbitration (bounced) unmodified, still type 00, so it recirculates on the ring and retries.
REQ-021 SHALL assert LCL_RD_VALID one cycle after a granted local read, with LCL_RD_DATA = RD_DATA; no pulse for local writes.
REQ-022 SHALL support back-to-back local grants every cycle while LCL_REQ is high and no Raccoon hit is present.
REQ-023 SHALL respond to Raccoon writes as to reads (type 10, data field = RD_DATA).
REQ-024 SHALL pass non-matching beats, responses (type != 00), and invalid beats through untouched.

Reset
REQ-025 SHALL, while RST low at a clock edge, clear din, din_d1, win_d1, RaccOut, starve_cnt and the read-valid register to 0.
REQ-026 SHALL force CS and LCL_GNT to 0 while RST is low.
REQ-027 SHALL present a clean pipeline after reset deassertion: first RaccOut beat equals RaccIn from three cycles earlier; no stale grant or read-valid.

Structure
REQ-028 SHALL take Raccoon field positions (valid, write, type, mask, data, address) and type encodings (00 request, 10 response) from shared package raccoon_pkg.
REQ-029 SHALL implement the saturating starvation counter as one sub-module, raccoon_starve_cnt; the rest is flat.

Verification
REQ-030 Idle local, Raccoon read 0x00010010, RAM word 0xCAFEF00D -> RaccOut 3 cycles later: type 10, data 0xCAFEF00D, address unchanged.
REQ-031 Raccoon write 0x00010004, data 0x11223344, mask 4'b0011 -> CS=WE=1, MASK=0011 in the cycle after input; type 10 response 2 cycles later.
REQ-032 LCL_REQ read 0x00010020, no Raccoon traffic -> LCL_GNT same cycle; LCL_RD_VALID next cycle with RAM contents.
REQ-033 LCL_REQ held; Raccoon hits on 10 consecutive cycles; STARVE_LIMIT=8 -> first 8 hits serviced; cycle 9 LCL_GNT=1 and that hit exits unmodified as type 00; starve_cnt back to 0.
REQ-034 Raccoon beat to address 0x00020000 and a type-10 beat -> both exit bit-exact after 3 cycles, CS=0.
REQ-035 RST low for one cycle mid-traffic with a local read granted the cycle before -> RaccOut=0, LCL_RD_VALID=0, CS=0 following reset; normal service resumes.
